mem_access_ctrl: RTL and testbench

//  CPU-side memory initiator: sequences one read or write to the 512x32 ram
//  (level-sensitive read/write strobes, address, data_in, data_out) per control-unit request.

---
 rtl/mem_access_ctrl_if.sv | 27 ++
 rtl/mem_access_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bundle between the control unit, the memory access controller and the 512x32 ram.
// slave is the controller's view; master is the environment (control unit plus ram).
interface mem_access_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        addr_err;
    logic [31:0] rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data_out;

    modport slave (
        input  req, we, addr, wdata, mem_data_out,
        output busy, done, addr_err, rdata, mem_address, mem_data_in, mem_read, mem_write
    );

    modport master (
        output req, we, addr, wdata, mem_data_out,
        input  busy, done, addr_err, rdata, mem_address, mem_data_in, mem_read, mem_write
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences one ram read or write per request.
// Address and data are set up one cycle before the strobe and held one cycle after it.
//
// state  | meaning
// IDLE   | waiting for req; address/data hold the last access
// SETUP  | address/data stable, strobes low, range check
// ACCESS | strobe high for WAIT_STATES+1 cycles (suppressed on range error)
// HOLD   | strobes low, address/data held, done/addr_err pulse
module mem_access_ctrl #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADDR_DEPTH  = 512
) (
    input logic           clk,
    input logic           clr,
    mem_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic [31:0] DEPTH     = 32'(ADDR_DEPTH);

    state_t      state_q, state_nxt;
    logic [3:0]  wait_cnt_q, wait_cnt_nxt;
    logic        err_q, err_nxt;
    logic        we_q, we_nxt;
    logic [31:0] address_q, address_nxt;
    logic [31:0] data_q, data_nxt;
    logic        read_q, read_nxt;
    logic        write_q, write_nxt;
    logic        done_q, done_nxt;
    logic        addr_err_q, addr_err_nxt;
    logic [31:0] rdata_q, rdata_nxt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            address_q  <= 32'd0;
            data_q     <= 32'd0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_nxt;
            wait_cnt_q <= wait_cnt_nxt;
            err_q      <= err_nxt;
            we_q       <= we_nxt;
            address_q  <= address_nxt;
            data_q     <= data_nxt;
            read_q     <= read_nxt;
            write_q    <= write_nxt;
            done_q     <= done_nxt;
            addr_err_q <= addr_err_nxt;
            rdata_q    <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        wait_cnt_nxt = wait_cnt_q;
        err_nxt      = err_q;
        we_nxt       = we_q;
        address_nxt  = address_q;
        data_nxt     = data_q;
        read_nxt     = 1'b0;
        write_nxt    = 1'b0;
        done_nxt     = 1'b0;
        addr_err_nxt = 1'b0;
        rdata_nxt    = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_nxt      = bus.we;
                    address_nxt = bus.addr;
                    data_nxt    = bus.wdata;
                    err_nxt     = 1'b0;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                // Full 32-bit compare: high address bits never alias back into range.
                err_nxt      = (address_q >= DEPTH);
                wait_cnt_nxt = WAIT_LOAD;
                read_nxt     = ~we_q & ~err_nxt;
                write_nxt    = we_q & ~err_nxt;
                state_nxt    = ACCESS;
            end
            ACCESS: begin
                if (wait_cnt_q == 4'd0) begin
                    done_nxt     = 1'b1;
                    addr_err_nxt = err_q;
                    state_nxt    = HOLD;
                    if (!we_q) begin
                        rdata_nxt = err_q ? 32'd0 : bus.mem_data_out;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt_q - 4'd1;
                    read_nxt     = read_q;
                    write_nxt    = write_q;
                end
            end
            HOLD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.addr_err    = addr_err_q;
    assign bus.rdata       = rdata_q;
    assign bus.mem_address = address_q;
    assign bus.mem_data_in = data_q;
    assign bus.mem_read    = read_q;
    assign bus.mem_write   = write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Two controllers (WAIT_STATES 1 and 3) against a ram model, checked every cycle
// against an access-timeline model plus hand-computed literals.
module tb_mem_access_ctrl;

    logic clk;
    logic clr;
    logic ram_load;

    logic        req_v     [2];
    logic        we_v      [2];
    logic [31:0] addr_v    [2];
    logic [31:0] wdata_v   [2];
    logic        busy_v    [2];
    logic        done_v    [2];
    logic        aerr_v    [2];
    logic [31:0] rdata_v   [2];
    logic [31:0] maddr_v   [2];
    logic [31:0] mdin_v    [2];
    logic        mrd_v     [2];
    logic        mwr_v     [2];

    int checks   = 0;
    int failures = 0;

    function automatic int ws(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] init_val(input int i);
        case (i)
            149:     return 32'hD;
            69:      return 32'h3;
            51:      return 32'h7;
            43:      return 32'h2;
            default: return 32'h1000_0000 | 32'(i);
        endcase
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'd512;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_access_ctrl_if ifc ();
        logic [31:0] ram [512];

        mem_access_ctrl #(.WAIT_STATES(g == 0 ? 1 : 3), .ADDR_DEPTH(512)) dut (
            .clk (clk),
            .clr (clr),
            .bus (ifc.slave)
        );

        assign ifc.req   = req_v[g];
        assign ifc.we    = we_v[g];
        assign ifc.addr  = addr_v[g];
        assign ifc.wdata = wdata_v[g];
        assign ifc.mem_data_out = (ifc.mem_address < 32'd512) ? ram[ifc.mem_address[8:0]] : 32'hBAD0_BAD0;

        always @(posedge clk) begin
            if (ram_load) begin
                for (int i = 0; i < 512; i++) ram[i] <= init_val(i);
            end else if (ifc.mem_write && ifc.mem_address < 32'd512) begin
                ram[ifc.mem_address[8:0]] <= ifc.mem_data_in;
            end
        end

        assign busy_v[g]  = ifc.busy;
        assign done_v[g]  = ifc.done;
        assign aerr_v[g]  = ifc.addr_err;
        assign rdata_v[g] = ifc.rdata;
        assign maddr_v[g] = ifc.mem_address;
        assign mdin_v[g]  = ifc.mem_data_in;
        assign mrd_v[g]   = ifc.mem_read;
        assign mwr_v[g]   = ifc.mem_write;
    end

    // Model: mk = cycles since acceptance (0 = idle). k=1 setup, 2..W+2 strobe, W+3 done.
    int          mk      [2];
    logic        m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];
    logic [31:0] sh      [2][512];
    bit          wr_valid[2][512];

    function automatic logic [31:0] model_mem(input int g, input logic [31:0] a);
        return wr_valid[g][a[8:0]] ? sh[g][a[8:0]] : init_val(int'(a[8:0]));
    endfunction

    always @(posedge clk or posedge clr) begin
        for (int g = 0; g < 2; g++) begin
            if (clr) begin
                mk[g]      <= 0;
                m_we[g]    <= 1'b0;
                m_addr[g]  <= 32'd0;
                m_wdata[g] <= 32'd0;
                m_rdata[g] <= 32'd0;
            end else if (mk[g] == 0) begin
                if (req_v[g]) begin
                    mk[g]      <= 1;
                    m_we[g]    <= we_v[g];
                    m_addr[g]  <= addr_v[g];
                    m_wdata[g] <= wdata_v[g];
                end
            end else if (mk[g] == ws(g) + 3) begin
                mk[g] <= 0;
            end else begin
                mk[g] <= mk[g] + 1;
                if (mk[g] == ws(g) + 2) begin
                    if (!m_we[g]) begin
                        m_rdata[g] <= in_range(m_addr[g]) ? model_mem(g, m_addr[g]) : 32'd0;
                    end else if (in_range(m_addr[g])) begin
                        sh[g][m_addr[g][8:0]]       <= m_wdata[g];
                        wr_valid[g][m_addr[g][8:0]] <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", name, g, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            automatic bit acc  = (mk[g] >= 2) && (mk[g] <= ws(g) + 2) && in_range(m_addr[g]);
            automatic bit dn   = (mk[g] == ws(g) + 3);
            chk("busy",        g, 32'(busy_v[g]), 32'(mk[g] != 0));
            chk("mem_read",    g, 32'(mrd_v[g]),  32'(acc && !m_we[g]));
            chk("mem_write",   g, 32'(mwr_v[g]),  32'(acc && m_we[g]));
            chk("done",        g, 32'(done_v[g]), 32'(dn));
            chk("addr_err",    g, 32'(aerr_v[g]), 32'(dn && !in_range(m_addr[g])));
            chk("rdata",       g, rdata_v[g], m_rdata[g]);
            chk("mem_address", g, maddr_v[g], m_addr[g]);
            chk("mem_data_in", g, mdin_v[g],  m_wdata[g]);
        end
    end

    task automatic do_access(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                             input int pulse_at, input logic [31:0] pa,
                             output int lat, output int rd, output int wr, output int both,
                             output int dn, output int dae);
        bit finished;
        lat = 0; rd = 0; wr = 0; both = 0; dn = 0; dae = 0; finished = 0;
        @(posedge clk); #1;
        req_v[g] = 1'b1; we_v[g] = w; addr_v[g] = a; wdata_v[g] = d;
        @(posedge clk); #1;
        req_v[g] = 1'b0;
        for (int i = 1; i <= 40 && !finished; i++) begin
            @(negedge clk);
            if (!busy_v[g]) begin
                finished = 1;
            end else begin
                if (mrd_v[g]) rd++;
                if (mwr_v[g]) wr++;
                if (mrd_v[g] && mwr_v[g]) both++;
                if (done_v[g]) begin
                    dn++;
                    if (lat == 0) lat = i;
                    if (aerr_v[g]) dae++;
                end
            end
            if (i == pulse_at) begin
                req_v[g] = 1'b1; we_v[g] = 1'b0; addr_v[g] = pa;
            end else begin
                req_v[g] = 1'b0;
            end
        end
        req_v[g] = 1'b0;
        if (!finished) chk("busy_timeout", g, 32'(busy_v[g]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rd, wr, both, dn, dae;
        for (int g = 0; g < 2; g++) begin
            req_v[g] = 1'b0; we_v[g] = 1'b0; addr_v[g] = 32'd0; wdata_v[g] = 32'd0;
        end
        ram_load = 1'b1;
        clr = 1'b0;
        #1 clr = 1'b1;
        @(posedge clk); #1;
        ram_load = 1'b0;
        #2 clr = 1'b0;
        @(negedge clk);
        chk("reset_busy",  0, 32'(busy_v[0]), 32'd0);
        chk("reset_rdata", 0, rdata_v[0], 32'd0);
        chk("reset_addr",  0, maddr_v[0], 32'd0);
        chk("reset_done",  1, 32'(done_v[1]), 32'd0);

        // 1: read preloaded word, W=1
        do_access(0, 1'b0, 32'd149, 32'd0, 0, 32'd0, lat, rd, wr, both, dn, dae);
        chk("t1_latency",    0, 32'(lat), 32'd4);
        chk("t1_read_width", 0, 32'(rd),  32'd2);
        chk("t1_no_write",   0, 32'(wr),  32'd0);
        chk("t1_rdata",      0, rdata_v[0], 32'hD);

        // 2: write then read back
        do_access(0, 1'b1, 32'h87, 32'h43, 0, 32'd0, lat, rd, wr, both, dn, dae);
        chk("t2_write_width", 0, 32'(wr),   32'd2);
        chk("t2_no_read",     0, 32'(rd),   32'd0);
        chk("t2_no_overlap",  0, 32'(both), 32'd0);
        chk("t2_rdata_kept",  0, rdata_v[0], 32'hD);
        do_access(0, 1'b0, 32'h87, 32'd0, 0, 32'd0, lat, rd, wr, both, dn, dae);
        chk("t2_readback", 0, rdata_v[0], 32'h43);

        // 3: out-of-range read, plus a high address that would alias 149 if truncated
        do_access(0, 1'b0, 32'd600, 32'd0, 0, 32'd0, lat, rd, wr, both, dn, dae);
        chk("t3_no_read",   0, 32'(rd),  32'd0);
        chk("t3_no_write",  0, 32'(wr),  32'd0);
        chk("t3_err_pulse", 0, 32'(dae), 32'd1);
        chk("t3_one_done",  0, 32'(dn),  32'd1);
        chk("t3_rdata",     0, rdata_v[0], 32'd0);
        do_access(0, 1'b0, 32'h8000_0095, 32'd0, 0, 32'd0, lat, rd, wr, both, dn, dae);
        chk("t3_hi_err",   0, 32'(dae), 32'd1);
        chk("t3_hi_rdata", 0, rdata_v[0], 32'd0);

        // 4: req pulse during ACCESS is ignored
        do_access(0, 1'b0, 32'd69, 32'd0, 3, 32'd43, lat, rd, wr, both, dn, dae);
        chk("t4_one_done", 0, 32'(dn), 32'd1);
        chk("t4_rdata",    0, rdata_v[0], 32'h3);
        repeat (3) @(negedge clk);
        chk("t4_addr_held", 0, maddr_v[0], 32'd69);
        chk("t4_idle",      0, 32'(busy_v[0]), 32'd0);

        // 5: clr in the middle of a write
        @(posedge clk); #1;
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'd300; wdata_v[0] = 32'h55;
        @(posedge clk); #1;
        req_v[0] = 1'b0;
        @(posedge clk); #1;
        chk("t5_write_on", 0, 32'(mwr_v[0]), 32'd1);
        @(posedge clk); #2;
        clr = 1'b1;
        #1;
        chk("t5_write_dropped", 0, 32'(mwr_v[0]),  32'd0);
        chk("t5_busy_dropped",  0, 32'(busy_v[0]), 32'd0);
        @(negedge clk); #2;
        clr = 1'b0;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_v[0]) dn++;
        end
        chk("t5_no_done", 0, 32'(dn), 32'd0);
        do_access(0, 1'b0, 32'd51, 32'd0, 0, 32'd0, lat, rd, wr, both, dn, dae);
        chk("t5_latency", 0, 32'(lat), 32'd4);
        chk("t5_rdata",   0, rdata_v[0], 32'h7);

        // 6: W=3 controller, plus range boundary 511/512
        do_access(1, 1'b0, 32'd43, 32'd0, 0, 32'd0, lat, rd, wr, both, dn, dae);
        chk("t6_read_width", 1, 32'(rd),  32'd4);
        chk("t6_latency",    1, 32'(lat), 32'd6);
        chk("t6_rdata",      1, rdata_v[1], 32'h2);
        do_access(1, 1'b0, 32'd511, 32'd0, 0, 32'd0, lat, rd, wr, both, dn, dae);
        chk("t6_edge_in",  1, rdata_v[1], 32'h1000_01FF);
        chk("t6_edge_err", 1, 32'(dae),   32'd0);
        do_access(1, 1'b1, 32'd512, 32'hABCD, 0, 32'd0, lat, rd, wr, both, dn, dae);
        chk("t6_oob_write",  1, 32'(wr),  32'd0);
        chk("t6_oob_err",    1, 32'(dae), 32'd1);
        chk("t6_rdata_kept", 1, rdata_v[1], 32'h1000_01FF);
        do_access(1, 1'b1, 32'd10, 32'hCAFE_0001, 0, 32'd0, lat, rd, wr, both, dn, dae);
        chk("t6_write_width", 1, 32'(wr), 32'd4);
        do_access(1, 1'b0, 32'd10, 32'd0, 0, 32'd0, lat, rd, wr, both, dn, dae);
        chk("t6_readback", 1, rdata_v[1], 32'hCAFE_0001);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
